// File: rtl/dmi_uart_bridge.sv
// Byte-serial UART front end for a RISC-V DMI port: parses read/write command frames,
// issues one DMI request at a time and streams the status (and read data) back over UART.
module dmi_uart_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 41667
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [1:0]  dmi_req_op_o,
  output logic [6:0]  dmi_req_addr_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_resp_i,
  output logic        rx_overrun_o
);

  localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYCLES);
  localparam logic [1:0]  OP_READ     = 2'd1;
  localparam logic [1:0]  OP_WRITE    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_RESP, S_TX_STAT, S_TX_DATA, S_TX_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [19:0] timer_q, timer_d;
  logic        overrun_q, overrun_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      addr_q    <= 7'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      resp_q    <= 2'd0;
      cnt_q     <= 2'd0;
      timer_q   <= 20'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    resp_d           = resp_q;
    cnt_d            = cnt_q;
    timer_d          = 20'd0;
    overrun_d        = overrun_q;
    tx_valid_o       = 1'b0;
    tx_data_o        = 8'h00;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == 8'h01) begin
            op_d    = OP_READ;
            state_d = S_ADDR;
          end else if (rx_data_i == 8'h02) begin
            op_d    = OP_WRITE;
            state_d = S_ADDR;
          end else if (rx_data_i != 8'h00) begin
            state_d = S_TX_ERR;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i[6:0];
          cnt_d   = 2'd0;
          state_d = (op_q == OP_READ) ? S_REQ : S_DATA;
        end else begin
          timer_d = timer_q + 20'd1;
          if (timer_d == TIMEOUT_LIM) begin
            timer_d = 20'd0;
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid_i) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + 20'd1;
          if (timer_d == TIMEOUT_LIM) begin
            timer_d = 20'd0;
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end
        end
      end
      S_REQ: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_resp_i;
          rdata_d = dmi_resp_data_i;
          state_d = S_TX_STAT;
        end
      end
      S_TX_STAT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {6'b0, resp_q};
        if (tx_ready_i) begin
          cnt_d   = 2'd0;
          state_d = (op_q == OP_READ && resp_q == 2'd0) ? S_TX_DATA : S_IDLE;
        end
      end
      S_TX_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rdata_q[{cnt_q, 3'b000} +: 8];
        if (tx_ready_i) begin
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_TX_ERR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'hEE;
        if (tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while a transaction is in flight are dropped and flagged.
    if (rx_valid_i && state_q != S_IDLE && state_q != S_ADDR && state_q != S_DATA) begin
      overrun_d = 1'b1;
    end
  end

  assign dmi_req_op_o   = op_q;
  assign dmi_req_addr_o = addr_q;
  assign dmi_req_data_o = wdata_q;
  assign rx_overrun_o   = overrun_q;

endmodule

// File: doc/dmi_uart_bridge.md
DMI_UART_BRIDGE -- requirements
Module: dmi_uart_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 41667, inter-byte timeout in clk_i cycles (1 ms at 41.67 MHz); legal range 2..2^20-1.
REQ-002 clk_i  in  1  single system clock; all logic on rising edge.
REQ-003 rst_ni  in  1  asynchronous active-low reset.
REQ-004 rx_valid_i  in  1  one-cycle strobe; a received UART byte is present.
REQ-005 rx_data_i  in  8  received byte, valid with rx_valid_i.
REQ-006 tx_valid_o  out  1  response byte offered to UART transmitter.
REQ-007 tx_data_o  out  8  response byte.
REQ-008 tx_ready_i  in  1  transmitter accepts byte when tx_valid_o & tx_ready_i.
REQ-009 dmi_req_valid_o  out  1  DMI request valid.
REQ-010 dmi_req_ready_i  in  1  debug module accepts request.
REQ-011 dmi_req_op_o  out  2  1 = read, 2 = write.
REQ-012 dmi_req_addr_o  out  7  DMI register address.
REQ-013 dmi_req_data_o  out  32  write data.
REQ-014 dmi_resp_valid_i  in  1  DMI response valid.
REQ-015 dmi_resp_ready_o  out  1  bridge accepts response.
REQ-016 dmi_resp_data_i  in  32  read data.
REQ-017 dmi_resp_resp_i  in  2  DMI status (0 ok, 2 failed, 3 busy).
REQ-018 rx_overrun_o  out  1  sticky flag; byte arrived while bridge busy.

Function
REQ-019 States: IDLE, ADDR, DATA, REQ, RESP, TX_STAT, TX_DATA, TX_ERR.
REQ-020 IDLE: rx byte 0x01 -> ADDR (op=read); 0x02 -> ADDR (op=write); other non-zero -> TX_ERR; 0x00 ignored.
REQ-021 ADDR: rx byte bits[6:0] latched to dmi_req_addr_o; bit 7 ignored; read -> REQ, write -> DATA with byte counter = 0.
REQ-022 DATA: four bytes, little-endian, into dmi_req_data_o[8k+7:8k] for k=0..3; after the fourth byte -> REQ.
REQ-023 Inter-byte timer in ADDR/DATA: reloads on each rx byte; reaching TIMEOUT_CYCLES without a byte -> IDLE; partial frame discarded; no DMI request; no tx.
REQ-024 REQ: dmi_req_valid_o = 1; op/addr/data stable until handshake; dmi_req_valid_o & dmi_req_ready_i -> RESP next cycle.
REQ-025 RESP: dmi_resp_ready_o = 1; on dmi_resp_valid_i latch resp and data -> TX_STAT.
REQ-026 dmi_resp_ready_o = 0 in every state except RESP; a response in any other state is ignored.
REQ-027 TX_STAT: tx_data_o = {6'b0, latched resp}; on accept -> TX_DATA if op = read and resp = 0, else IDLE.
REQ-028 TX_DATA: four bytes, read data little-endian, one per accepted handshake; after the fourth -> IDLE.
REQ-029 TX_ERR: tx_data_o = 0xEE; on accept -> IDLE.
REQ-030 tx_valid_o = 1 only in TX_STAT, TX_DATA, TX_ERR; tx_data_o stable while tx_valid_o & ~tx_ready_i.
REQ-031 rx_valid_i in REQ, RESP, or any TX state: byte dropped; rx_overrun_o set to 1.
REQ-032 No DMI request or response timeout; the bridge waits indefinitely in REQ/RESP.
REQ-033 Throughput: at most one DMI transaction outstanding; a new command is accepted only in IDLE.
REQ-034 rx_valid_i on the same cycle as the timeout expiry: the byte wins; timer reloads and the frame continues.

Reset
REQ-035 rst_ni low -> state IDLE immediately; all handshake outputs (tx_valid_o, dmi_req_valid_o, dmi_resp_ready_o) 0; tx_data_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o 0; timer and byte counters 0; rx_overrun_o 0.
REQ-036 Reset mid-transaction abandons the frame; no tx byte or DMI request is issued after deassertion until a new command arrives.
REQ-037 rx_overrun_o is cleared only by reset.

Verification
REQ-038 Write: rx 02,10,78,56,34,12; ready=1; resp=0 -> one request, op=2, addr=0x10, data=0x12345678; tx 00; state IDLE.
REQ-039 Read: rx 01,11; resp data=0xDEADBEEF, resp=0 -> op=1, addr=0x11; tx 00,EF,BE,AD,DE.
REQ-040 Read with resp=3 -> tx 03 only; state IDLE.
REQ-041 Timeout: TIMEOUT_CYCLES=16; rx 02,10,AA, then 16 idle cycles -> no dmi_req_valid_o, no tx; next rx 01,04 proceeds normally.
REQ-042 Backpressure: tx_ready_i=0 for 5 cycles during TX_DATA -> tx_data_o held constant; bytes are not duplicated or skipped.
REQ-043 Overrun and error: rx 05 -> tx EE; rx byte during RESP -> rx_overrun_o=1 and it persists; reset asserted during REQ -> all outputs 0 asynchronously.
